// File: rtl/sgd_step_scheduler_if.sv
// Handshake/config bundle between the training controller, the SGD step
// scheduler and the datapath it feeds.
interface sgd_step_scheduler_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int MUL_LANES  = 3
);
  logic                  start;
  logic [3:0]            feat;
  logic [ADDR_WIDTH-1:0] data_points;
  logic [7:0]            epoch;
  logic                  hold;
  logic                  step_ready;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  rd_en;
  logic                  step_valid;
  logic [1:0]            phase;
  logic [3:0]            chunk_base;
  logic [MUL_LANES-1:0]  lane_en;
  logic [7:0]            epoch_count;
  logic                  busy;
  logic                  done;

  modport master (
    output start, feat, data_points, epoch, hold, step_ready,
    input  addr, rd_en, step_valid, phase, chunk_base, lane_en, epoch_count, busy, done
  );

  modport slave (
    input  start, feat, data_points, epoch, hold, step_ready,
    output addr, rd_en, step_valid, phase, chunk_base, lane_en, epoch_count, busy, done
  );
endinterface

// File: rtl/sgd_step_scheduler.sv
// SGD step sequencer: walks points/epochs, issues RAM reads and hands the
// datapath one LOADW/PRED/ERR/UPD step per handshake.
module sgd_step_scheduler #(
  parameter int ADDR_WIDTH   = 12,
  parameter int MAX_FEATURES = 15,
  parameter int MUL_LANES    = 3
) (
  input logic                CLK,
  input logic                RST,
  sgd_step_scheduler_if.slave bus
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_STEP, S_PARK, S_DONE} state_e;

  localparam logic [1:0] PH_LOADW = 2'd0;
  localparam logic [1:0] PH_PRED  = 2'd1;
  localparam logic [1:0] PH_ERR   = 2'd2;
  localparam logic [1:0] PH_UPD   = 2'd3;

  state_e                state_q, state_d;
  logic                  resume_fetch_q, resume_fetch_d;
  logic [3:0]            feat_q, feat_d;
  logic [ADDR_WIDTH-1:0] dp_q, dp_d;
  logic [7:0]            ep_q, ep_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [1:0]            phase_q, phase_d;
  logic [2:0]            chunk_q, chunk_d;
  logic [7:0]            ep_cnt_q, ep_cnt_d;
  logic                  done_q, done_d;
  logic                  rd_en_q, rd_en_d;
  logic                  step_valid_q, step_valid_d;
  logic                  busy_q, busy_d;
  logic [3:0]            chunk_base_q, chunk_base_d;
  logic [MUL_LANES-1:0]  lane_en_q, lane_en_d;

  logic       nxt_step, nxt_fetch, eop, last_chunk;
  logic [5:0] base_q_w, base_d_w;

  // A chunk is the last one once its lane window reaches past feat.
  assign base_q_w   = 6'd1 + 6'(MUL_LANES) * 6'(chunk_q);
  assign last_chunk = (base_q_w + 6'(MUL_LANES)) > {2'b00, feat_q};

  always_comb begin
    state_d        = state_q;
    resume_fetch_d = resume_fetch_q;
    feat_d         = feat_q;
    dp_d           = dp_q;
    ep_d           = ep_q;
    addr_d         = addr_q;
    phase_d        = phase_q;
    chunk_d        = chunk_q;
    ep_cnt_d       = ep_cnt_q;
    done_d         = done_q;
    nxt_step       = 1'b0;
    nxt_fetch      = 1'b0;
    eop            = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: if (bus.start) begin
        feat_d = ({1'b0, bus.feat} > 5'(MAX_FEATURES)) ? 4'(MAX_FEATURES) : bus.feat;
        dp_d   = bus.data_points;
        ep_d   = bus.epoch;
        if (bus.data_points == '0 || bus.epoch == '0) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          done_d   = 1'b0;
          ep_cnt_d = '0;
          addr_d   = '0;
          phase_d  = PH_LOADW;
          chunk_d  = '0;
          state_d  = S_FETCH;
        end
      end
      S_FETCH: state_d = S_WAIT;
      S_WAIT:  nxt_step = 1'b1;
      S_STEP: if (bus.step_ready) begin
        case (phase_q)
          PH_LOADW: begin
            addr_d    = ADDR_WIDTH'(1);
            phase_d   = (feat_q == '0) ? PH_ERR : PH_PRED;
            chunk_d   = '0;
            nxt_fetch = 1'b1;
          end
          PH_PRED: begin
            if (last_chunk) begin
              phase_d = PH_ERR;
              chunk_d = '0;
            end else begin
              chunk_d = chunk_q + 3'd1;
            end
            nxt_step = 1'b1;
          end
          PH_ERR: begin
            if (feat_q == '0) eop = 1'b1;
            else begin
              phase_d  = PH_UPD;
              chunk_d  = '0;
              nxt_step = 1'b1;
            end
          end
          default: begin
            if (last_chunk) eop = 1'b1;
            else begin
              chunk_d  = chunk_q + 3'd1;
              nxt_step = 1'b1;
            end
          end
        endcase
      end
      S_PARK: if (!bus.hold) state_d = resume_fetch_q ? S_FETCH : S_STEP;
      default: state_d = S_IDLE;
    endcase

    if (eop) begin
      phase_d = (feat_q == '0) ? PH_ERR : PH_PRED;
      chunk_d = '0;
      if (addr_q < dp_q) begin
        addr_d    = addr_q + ADDR_WIDTH'(1);
        nxt_fetch = 1'b1;
      end else begin
        ep_cnt_d = ep_cnt_q + 8'd1;
        if (ep_cnt_d == ep_q) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          addr_d  = '0;
        end else begin
          addr_d    = ADDR_WIDTH'(1);
          nxt_fetch = 1'b1;
        end
      end
    end

    // Hold only parks at step boundaries; the target is remembered for resume.
    if (nxt_step || nxt_fetch) begin
      resume_fetch_d = nxt_fetch;
      if (bus.hold)       state_d = S_PARK;
      else if (nxt_fetch) state_d = S_FETCH;
      else                state_d = S_STEP;
    end
  end

  always_comb begin
    base_d_w     = 6'd1 + 6'(MUL_LANES) * 6'(chunk_d);
    chunk_base_d = base_d_w[3:0];
    lane_en_d    = '0;
    for (int i = 0; i < MUL_LANES; i++)
      lane_en_d[i] = (phase_d == PH_PRED || phase_d == PH_UPD) &&
                     ((base_d_w + 6'(i)) <= {2'b00, feat_d});
    rd_en_d      = (state_d == S_FETCH);
    step_valid_d = (state_d == S_STEP);
    busy_d       = !(state_d inside {S_IDLE, S_DONE});
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q        <= S_IDLE;
      resume_fetch_q <= 1'b0;
      feat_q         <= '0;
      dp_q           <= '0;
      ep_q           <= '0;
      addr_q         <= '0;
      phase_q        <= PH_LOADW;
      chunk_q        <= '0;
      ep_cnt_q       <= '0;
      done_q         <= 1'b0;
      rd_en_q        <= 1'b0;
      step_valid_q   <= 1'b0;
      busy_q         <= 1'b0;
      chunk_base_q   <= '0;
      lane_en_q      <= '0;
    end else begin
      state_q        <= state_d;
      resume_fetch_q <= resume_fetch_d;
      feat_q         <= feat_d;
      dp_q           <= dp_d;
      ep_q           <= ep_d;
      addr_q         <= addr_d;
      phase_q        <= phase_d;
      chunk_q        <= chunk_d;
      ep_cnt_q       <= ep_cnt_d;
      done_q         <= done_d;
      rd_en_q        <= rd_en_d;
      step_valid_q   <= step_valid_d;
      busy_q         <= busy_d;
      chunk_base_q   <= chunk_base_d;
      lane_en_q      <= lane_en_d;
    end
  end

  assign bus.addr        = addr_q;
  assign bus.rd_en       = rd_en_q;
  assign bus.step_valid  = step_valid_q;
  assign bus.phase       = phase_q;
  assign bus.chunk_base  = chunk_base_q;
  assign bus.lane_en     = lane_en_q;
  assign bus.epoch_count = ep_cnt_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;

endmodule

// File: doc/sgd_step_scheduler.md
Name: sgd_step_scheduler

Overview:
- Control sequencer for the SGD training datapath: walks data points and epochs, generates RAM read addresses, and issues one datapath step per handshake.
- Splits each data point into a weight load, prediction chunks, an error step and weight-update chunks.
- Each chunk of up to MUL_LANES features is sized to the shared 3-multiplier array (bw_mul lanes).
- Sits between the data-point RAM and the SGD arithmetic datapath; the datapath only executes the step it is handed.

Parameters:
- ADDR_WIDTH, 12, RAM address width and width of the data-point count.
- MAX_FEATURES, 15, maximum number of features per data point.
- MUL_LANES, 3, number of multiplier lanes consumed per chunk.

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- RST  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to begin training; sampled only in IDLE or DONE.
- feat  input  4  number of features, 0..MAX_FEATURES; latched at start.
- data_points  input  ADDR_WIDTH  number of data points; latched at start.
- epoch  input  8  number of epochs; latched at start.
- hold  input  1  pause request; takes effect at step boundaries.
- step_ready  input  1  datapath accepts the current step.
- addr  output  ADDR_WIDTH  RAM read address.
- rd_en  output  1  RAM read strobe; RAM read latency is 1 cycle.
- step_valid  output  1  a step is presented to the datapath.
- phase  output  2  step type: 0 = LOADW, 1 = PRED, 2 = ERR, 3 = UPD.
- chunk_base  output  4  first feature index of the chunk, 1-based.
- lane_en  output  MUL_LANES  per-lane enable; lane i is active when chunk_base+i <= feat.
- epoch_count  output  8  number of completed epochs.
- busy  output  1  high in every state except IDLE and DONE.
- done  output  1  level; training complete.

Behaviour:
- Reset, while RST=0 and asynchronously: state returns to IDLE immediately, even mid-operation. All outputs are 0, including addr, epoch_count and done. Latched configuration is cleared.
- States: IDLE, FETCH, WAIT, STEP, DONE.
  - A step counter selects the sub-step in STEP: LOADW, PRED[0..k-1], ERR, UPD[0..k-1], with k = ceil(feat/MUL_LANES). feat=0 gives k=0.
- IDLE/DONE, start=1:
  - Latch feat, data_points and epoch.
  - If data_points=0 or epoch=0, go directly to DONE with done=1.
  - Otherwise clear done and epoch_count, set addr=0 and enter FETCH (weight load).
  - start in any other state is ignored.
- FETCH: rd_en=1 for exactly one cycle at the current addr, then WAIT.
- WAIT: one cycle for RAM data, then STEP.
- STEP: step_valid=1. phase, chunk_base and lane_en must stay stable until step_valid and step_ready are high in the same cycle; the step advances on that cycle.
  - chunk_base = 1 + MUL_LANES*chunk index.
  - lane_en = 0 for LOADW and ERR.
- After each accepted step:
  - LOADW → set addr=1, go to FETCH.
  - PRED chunk j<k-1 → PRED j+1.
  - Last PRED, or LOADW completion with k=0 → ERR.
  - ERR → UPD 0, or end-of-point if k=0.
  - UPD chunk j<k-1 → UPD j+1.
  - Last UPD → end-of-point.
- End-of-point:
  - If addr < data_points: addr+1, FETCH.
  - Else epoch_count+1. If the new epoch_count = epoch, go to DONE (done=1, addr=0). Otherwise addr=1, FETCH.
- Per-point cost with step_ready tied high: 3+2k cycles (FETCH, WAIT, k PRED, ERR, k UPD). The weight load costs 3 cycles once per run.
- hold=1:
  - In STEP: the current step completes its handshake, then the scheduler parks before the next step or FETCH, with step_valid=0 and rd_en=0. The next step is re-presented, or FETCH entered, the cycle after hold falls.
  - In FETCH/WAIT: the in-flight read completes before parking.
  - No effect in IDLE/DONE.
- Addresses never exceed data_points. The 12-bit addr does not wrap because data_points <= 2^ADDR_WIDTH-1.
- feat > MAX_FEATURES is clamped to MAX_FEATURES at latch time.

Test Plan:
- Basic run: feat=7, data_points=4, epoch=2, step_ready=1, start pulse → done rises at the 75th rising edge after the edge sampling start (3 + 8×9). epoch_count=2. Address sequence 0,1,2,3,4,1,2,3,4.
- Lanes: feat=7 → PRED chunk_base sequence 1,4,7 with lane_en 111,111,001. ERR step has lane_en=000. UPD repeats 1,4,7.
- Edge configurations:
  - feat=0 → per point exactly FETCH, WAIT, ERR (3 cycles).
  - data_points=0 → done=1 on the cycle after start, rd_en never asserted.
- Back-pressure: step_ready low for 5 cycles during PRED chunk 1 → phase=1 and chunk_base=4 held stable all 5 cycles. The total run is exactly 5 cycles longer.
- Hold: assert hold for 10 cycles mid-UPD → the current handshake completes, then step_valid=0 and rd_en=0 for the hold duration. Resume with the next chunk; final epoch_count is unchanged.
- Reset mid-run: drive RST=0 during epoch 1 → busy, done, addr and epoch_count are 0 immediately, without waiting for CLK. A new start after reset performs a fresh full run.
